// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state,
// default widths and packed read-port slice arithmetic.
package reg_file_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } rf_state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;

   // LSB of port `port` inside a packed vector of `width`-bit fields
   function automatic int port_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: clear request, two write ports, issue port,
// packed read ports and status outputs.
interface reg_file_mp_if
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
);
   logic                       clr_req;
   logic                       ready;
   logic                       wr_en_a;
   logic [ADDR_W-1:0]          wr_addr_a;
   logic [DATA_W-1:0]          wr_data_a;
   logic                       wr_en_b;
   logic [ADDR_W-1:0]          wr_addr_b;
   logic [DATA_W-1:0]          wr_data_b;
   logic                       issue_en;
   logic [ADDR_W-1:0]          issue_addr;
   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD*DATA_W-1:0]   rd_data;
   logic [NUM_RD-1:0]          rd_pending;
   logic                       wr_collide;

   modport master (
      output clr_req, wr_en_a, wr_addr_a, wr_data_a,
             wr_en_b, wr_addr_b, wr_data_b, issue_en, issue_addr, rd_addr,
      input  ready, rd_data, rd_pending, wr_collide
   );

   modport slave (
      input  clr_req, wr_en_a, wr_addr_a, wr_data_a,
             wr_en_b, wr_addr_b, wr_data_b, issue_en, issue_addr, rd_addr,
      output ready, rd_data, rd_pending, wr_collide
   );
endinterface

// File: rtl/reg_file_bypass.sv
// One read port: picks stored value or same-cycle write data (B over A),
// applies zero-register suppression and masks pending on a bypass hit.
module reg_file_bypass #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              ready,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] stored,
   input  logic              stored_pend,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] wr_addr_a,
   input  logic [DATA_W-1:0] wr_data_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] wr_addr_b,
   input  logic [DATA_W-1:0] wr_data_b,
   output logic [DATA_W-1:0] data,
   output logic              pending
);
   logic hit_a, hit_b, zero_hit;

   assign hit_a    = (BYPASS != 0) && we_a && (wr_addr_a == rd_addr);
   assign hit_b    = (BYPASS != 0) && we_b && (wr_addr_b == rd_addr);
   assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);

   always_comb begin
      data    = '0;
      pending = 1'b0;
      if (ready && !zero_hit) begin
         if (hit_b)      data = wr_data_b;
         else if (hit_a) data = wr_data_a;
         else            data = stored;
         pending = stored_pend && !(hit_a || hit_b);
      end
   end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass, pending scoreboard and
// a clear sequencer that zeroes one entry per cycle after reset or request.
//   state    | meaning
//   ST_CLEAR | zeroing entry clr_idx each cycle; writes/issues ignored
//   ST_READY | normal operation; clr_req restarts the clear
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_mp_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   rf_state_t          state, state_nx;
   logic [ADDR_W-1:0]  clr_idx, clr_idx_nx;
   logic [DEPTH-1:0]   pend, pend_nx;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic               ready, accept, we_a, we_b;
   logic [DATA_W-1:0]  rd_word [NUM_RD];
   logic [NUM_RD-1:0]  rd_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
         pend    <= '0;
      end else begin
         state   <= state_nx;
         clr_idx <= clr_idx_nx;
         pend    <= pend_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      clr_idx_nx = clr_idx;
      case (state)
         ST_CLEAR: begin
            clr_idx_nx = clr_idx + 1'b1;
            if (&clr_idx) state_nx = ST_READY;
         end
         ST_READY: begin
            if (bus.clr_req) begin
               state_nx   = ST_CLEAR;
               clr_idx_nx = '0;
            end
         end
         default: state_nx = ST_CLEAR;
      endcase
   end

   assign ready  = (state == ST_READY);
   assign accept = ready && !bus.clr_req;
   assign we_a   = accept && bus.wr_en_a && !((ZERO_REG != 0) && (bus.wr_addr_a == '0));
   assign we_b   = accept && bus.wr_en_b && !((ZERO_REG != 0) && (bus.wr_addr_b == '0));

   assign bus.ready      = ready;
   assign bus.wr_collide = ready && bus.wr_en_a && bus.wr_en_b
                           && (bus.wr_addr_a == bus.wr_addr_b)
                           && !((ZERO_REG != 0) && (bus.wr_addr_a == '0));

   // Issue is applied after the write clears so a same-edge issue wins.
   always_comb begin
      pend_nx = pend;
      if (!accept) begin
         pend_nx = '0;
      end else begin
         if (we_a) pend_nx[bus.wr_addr_a] = 1'b0;
         if (we_b) pend_nx[bus.wr_addr_b] = 1'b0;
         if (bus.issue_en && !((ZERO_REG != 0) && (bus.issue_addr == '0)))
            pend_nx[bus.issue_addr] = 1'b1;
      end
   end

   // Storage has no reset; B is written last so it wins an address tie.
   always_ff @(posedge clk) begin
      if (!ready) begin
         mem[clr_idx] <= '0;
      end else begin
         if (we_a) mem[bus.wr_addr_a] <= bus.wr_data_a;
         if (we_b) mem[bus.wr_addr_b] <= bus.wr_data_b;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = bus.rd_addr[port_lo(i, ADDR_W) +: ADDR_W];

      reg_file_bypass #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_bypass (
         .ready       (ready),
         .rd_addr     (ra),
         .stored      (mem[ra]),
         .stored_pend (pend[ra]),
         .we_a        (we_a),
         .wr_addr_a   (bus.wr_addr_a),
         .wr_data_a   (bus.wr_data_a),
         .we_b        (we_b),
         .wr_addr_b   (bus.wr_addr_b),
         .wr_data_b   (bus.wr_data_b),
         .data        (rd_word[i]),
         .pending     (rd_pend[i])
      );
   end

   always_comb begin
      bus.rd_data = '0;
      for (int i = 0; i < NUM_RD; i++)
         bus.rd_data[port_lo(i, DATA_W) +: DATA_W] = rd_word[i];
   end

   assign bus.rd_pending = rd_pend;
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus
// and are checked every cycle against an array-based reference model.
module tb_reg_file_mp;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) b1 ();
   reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) b0 ();

   reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

   assign b0.clr_req    = b1.clr_req;
   assign b0.wr_en_a    = b1.wr_en_a;
   assign b0.wr_addr_a  = b1.wr_addr_a;
   assign b0.wr_data_a  = b1.wr_data_a;
   assign b0.wr_en_b    = b1.wr_en_b;
   assign b0.wr_addr_b  = b1.wr_addr_b;
   assign b0.wr_data_b  = b1.wr_data_b;
   assign b0.issue_en   = b1.issue_en;
   assign b0.issue_addr = b1.issue_addr;
   assign b0.rd_addr    = b1.rd_addr;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: storage array, pending flags, clear countdown.
   logic [31:0] m_mem [32];
   bit          m_pend [32];
   bit          m_ready;
   int          clr_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready <= 1'b0;
         clr_cnt <= 0;
         foreach (m_pend[k]) m_pend[k] <= 1'b0;
      end else if (!m_ready) begin
         m_mem[clr_cnt] <= 32'h0;
         clr_cnt <= clr_cnt + 1;
         if (clr_cnt == 31) m_ready <= 1'b1;
      end else if (b1.clr_req) begin
         m_ready <= 1'b0;
         clr_cnt <= 0;
         foreach (m_pend[k]) m_pend[k] <= 1'b0;
      end else begin
         if (b1.wr_en_a && b1.wr_addr_a != 5'd0) begin
            m_mem[b1.wr_addr_a]  <= b1.wr_data_a;
            m_pend[b1.wr_addr_a] <= 1'b0;
         end
         if (b1.wr_en_b && b1.wr_addr_b != 5'd0) begin
            m_mem[b1.wr_addr_b]  <= b1.wr_data_b;
            m_pend[b1.wr_addr_b] <= 1'b0;
         end
         if (b1.issue_en && b1.issue_addr != 5'd0) m_pend[b1.issue_addr] <= 1'b1;
      end
   end

   function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] r);
      if (!m_ready || r == 5'd0) return 32'h0;
      if (byp && !b1.clr_req) begin
         if (b1.wr_en_b && b1.wr_addr_b == r) return b1.wr_data_b;
         if (b1.wr_en_a && b1.wr_addr_a == r) return b1.wr_data_a;
      end
      return m_mem[r];
   endfunction

   function automatic bit exp_pend(input bit byp, input logic [4:0] r);
      if (!m_ready || r == 5'd0) return 1'b0;
      if (byp && !b1.clr_req &&
          ((b1.wr_en_b && b1.wr_addr_b == r) || (b1.wr_en_a && b1.wr_addr_a == r)))
         return 1'b0;
      return m_pend[r];
   endfunction

   function automatic bit exp_collide();
      return m_ready && b1.wr_en_a && b1.wr_en_b &&
             (b1.wr_addr_a == b1.wr_addr_b) && (b1.wr_addr_a != 5'd0);
   endfunction

   logic [4:0] cmp_ra;
   always @(negedge clk) begin
      chk("ready_byp", 64'(b1.ready), 64'(m_ready));
      chk("ready_nobyp", 64'(b0.ready), 64'(m_ready));
      chk("collide_byp", 64'(b1.wr_collide), 64'(exp_collide()));
      chk("collide_nobyp", 64'(b0.wr_collide), 64'(exp_collide()));
      for (int p = 0; p < 2; p++) begin
         cmp_ra = b1.rd_addr[p*5 +: 5];
         chk($sformatf("rd_data_byp[%0d]", p), 64'(b1.rd_data[p*32 +: 32]), 64'(exp_rd(1'b1, cmp_ra)));
         chk($sformatf("rd_data_nobyp[%0d]", p), 64'(b0.rd_data[p*32 +: 32]), 64'(exp_rd(1'b0, cmp_ra)));
         chk($sformatf("rd_pend_byp[%0d]", p), 64'(b1.rd_pending[p]), 64'(exp_pend(1'b1, cmp_ra)));
         chk($sformatf("rd_pend_nobyp[%0d]", p), 64'(b0.rd_pending[p]), 64'(exp_pend(1'b0, cmp_ra)));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b1.clr_req  = 1'b0;
      b1.wr_en_a  = 1'b0;
      b1.wr_en_b  = 1'b0;
      b1.issue_en = 1'b0;
   endtask

   task automatic count_clear(input string tag);
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i == 31) chk({tag, "_ready_low_31"}, 64'(b1.ready), 64'd0);
         if (i == 32) chk({tag, "_ready_high_32"}, 64'(b1.ready), 64'd1);
      end
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      idle();
      b1.wr_addr_a = '0; b1.wr_data_a = '0;
      b1.wr_addr_b = '0; b1.wr_data_b = '0;
      b1.issue_addr = '0; b1.rd_addr = '0;
      #2 rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      count_clear("reset");
      for (int r = 0; r < 32; r++) begin
         step();
         b1.rd_addr = {5'(r), 5'(r)};
         #1;
         chk("post_reset_rd", 64'(b1.rd_data), 64'd0);
         chk("post_reset_pend", 64'(b1.rd_pending), 64'd0);
      end

      // same-cycle write visibility
      step();
      b1.wr_en_a = 1'b1; b1.wr_addr_a = 5'd3; b1.wr_data_a = 32'hDEADBEEF;
      b1.rd_addr = {5'd0, 5'd3};
      #1;
      chk("bypass_same_cycle", 64'(b1.rd_data[31:0]), 64'hDEADBEEF);
      chk("nobypass_same_cycle", 64'(b0.rd_data[31:0]), 64'h0);
      step();
      b1.wr_en_a = 1'b0;
      #1;
      chk("nobypass_next_cycle", 64'(b0.rd_data[31:0]), 64'hDEADBEEF);

      // collision: B wins; address 0 suppressed
      b1.wr_en_a = 1'b1; b1.wr_addr_a = 5'd7; b1.wr_data_a = 32'h11;
      b1.wr_en_b = 1'b1; b1.wr_addr_b = 5'd7; b1.wr_data_b = 32'h22;
      #1;
      chk("collide_7", 64'(b1.wr_collide), 64'd1);
      step();
      idle();
      b1.rd_addr = {5'd7, 5'd0};
      b1.wr_en_a = 1'b1; b1.wr_addr_a = 5'd0; b1.wr_data_a = 32'h55;
      #1;
      chk("addr7_b_wins", 64'(b0.rd_data[63:32]), 64'h22);
      chk("addr0_bypass_zero", 64'(b1.rd_data[31:0]), 64'h0);
      step();
      idle();
      #1;
      chk("addr0_stays_zero", 64'(b0.rd_data[31:0]), 64'h0);

      // scoreboard
      b1.issue_en = 1'b1; b1.issue_addr = 5'd9;
      step();
      idle();
      b1.rd_addr = {5'd0, 5'd9};
      #1;
      chk("pend9_set", 64'(b1.rd_pending[0]), 64'd1);
      b1.wr_en_a = 1'b1; b1.wr_addr_a = 5'd9; b1.wr_data_a = 32'h99;
      #1;
      chk("pend9_masked_byp", 64'(b1.rd_pending[0]), 64'd0);
      chk("pend9_unmasked_nobyp", 64'(b0.rd_pending[0]), 64'd1);
      step();
      idle();
      #1;
      chk("pend9_cleared", 64'(b0.rd_pending[0]), 64'd0);
      b1.issue_en = 1'b1; b1.issue_addr = 5'd9;
      b1.wr_en_b = 1'b1; b1.wr_addr_b = 5'd9; b1.wr_data_b = 32'h98;
      step();
      idle();
      #1;
      chk("pend9_issue_wins", 64'(b0.rd_pending[0]), 64'd1);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         b1.clr_req    = ($urandom_range(0, 199) == 0);
         b1.wr_en_a    = 1'($urandom_range(0, 1));
         b1.wr_addr_a  = rnd_addr();
         b1.wr_data_a  = $urandom;
         b1.wr_en_b    = 1'($urandom_range(0, 1));
         b1.wr_addr_b  = rnd_addr();
         b1.wr_data_b  = $urandom;
         b1.issue_en   = 1'($urandom_range(0, 1));
         b1.issue_addr = rnd_addr();
         b1.rd_addr    = {rnd_addr(), rnd_addr()};
         step();
      end
      idle();
      for (int i = 0; i < 40 && !b1.ready; i++) step();
      chk("ready_after_random", 64'(b1.ready), 64'd1);

      // fill, then clear on request with writes held on
      for (int i = 1; i < 32; i++) begin
         b1.wr_en_a = 1'b1; b1.wr_addr_a = 5'(i); b1.wr_data_a = 32'(i) * 32'h0101_0101;
         step();
      end
      b1.wr_en_a = 1'b0;
      b1.rd_addr = {5'd0, 5'd17};
      #1;
      chk("fill_17", 64'(b1.rd_data[31:0]), 64'h1111_1111);
      b1.clr_req = 1'b1;
      b1.wr_en_b = 1'b1; b1.wr_addr_b = 5'd5; b1.wr_data_b = 32'hABCD;
      step();
      b1.clr_req = 1'b0; b1.wr_en_b = 1'b0;
      b1.wr_en_a = 1'b1; b1.wr_addr_a = 5'd6; b1.wr_data_a = 32'hFFFF_FFFF;
      b1.issue_en = 1'b1; b1.issue_addr = 5'd6;
      #1;
      chk("clr_ready_low", 64'(b1.ready), 64'd0);
      count_clear("clr_req");
      idle();
      for (int r = 0; r < 32; r++) begin
         step();
         b1.rd_addr = {5'(r), 5'(r)};
         #1;
         chk("post_clear_rd", 64'(b0.rd_data), 64'd0);
         chk("post_clear_pend", 64'(b0.rd_pending), 64'd0);
      end

      // reset in the middle of a clear
      b1.clr_req = 1'b1;
      step();
      b1.clr_req = 1'b0;
      repeat (10) step();
      b1.issue_en = 1'b1; b1.issue_addr = 5'd4;
      b1.rd_addr = {5'd0, 5'd4};
      rst_n = 1'b0;
      repeat (3) step();
      chk("midclear_reset_ready", 64'(b1.ready), 64'd0);
      chk("midclear_reset_pend", 64'(b1.rd_pending), 64'd0);
      rst_n = 1'b1;
      idle();
      count_clear("mid_reset");
      chk("mid_reset_pend4", 64'(b1.rd_pending[0]), 64'd0);

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout got running expected finished");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the pipeline decode/writeback stages. Provides NUM_RD combinational read ports, two clocked write ports, and same-cycle write-to-read bypass. A per-entry pending scoreboard tracks outstanding producers. After reset, or on request, a clear sequencer zeroes the storage one entry per cycle.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 hardwired to zero, never written, never pending
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
clrReq  in  1  single-cycle pulse; restarts clear sequence (honoured in READY only)
ready  out  1  1 = clear sequence done, block accepting writes and issues
wrEnA  in  1  write port A enable
wrAddrA  in  ADDR_W  write port A address
wrDataA  in  DATA_W  write port A data
wrEnB  in  1  write port B enable (priority port)
wrAddrB  in  ADDR_W  write port B address
wrDataB  in  DATA_W  write port B data
issueEn  in  1  mark issueAddr pending (producer issued)
issueAddr  in  ADDR_W  destination being issued
rdAddr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rdData  out  NUM_RD*DATA_W  packed read data
rdPending  out  NUM_RD  1 = read port i's register awaits a writeback
wrCollide  out  1  combinational; both write ports enabled to same non-suppressed address

Behaviour:
- FSM states: CLEAR, READY. rst_n low -> CLEAR, clrIdx=0, ready=0, all pending bits 0 (asynchronous). Storage array has no reset.
- CLEAR: each cycle writes 0 to entry clrIdx, clrIdx++. After entry 2**ADDR_W-1 -> READY, ready=1. First rising edge with rst_n high clears entry 0; ready rises after the 2**ADDR_W-th edge.
- While in CLEAR: wrEnA/B, issueEn, clrReq ignored; pending held at 0; rdData and rdPending forced 0.
- READY + clrReq -> CLEAR next edge, clrIdx=0, all pending cleared; writes/issue in that same cycle are dropped.
- rst_n asserted mid-sequence -> immediate restart from clrIdx=0.
- Writes: on rising edge when ready. Same address on A and B: B's data stored. Address 0 writes discarded when ZERO_REG=1 (wrCollide excludes addr 0).
- Reads: combinational, zero latency. Addr 0 returns 0 when ZERO_REG=1.
- BYPASS=1: if wrEnB matches rdAddr_i, return wrDataB; else if wrEnA matches, return wrDataA; else stored value. BYPASS=0: stored value only; new data visible the cycle after the write.
- Scoreboard: pend[k] set on edge when issueEn and issueAddr==k; cleared when wrEnA or wrEnB writes k. Same-edge issue and write to k: set wins (newer producer). Addr 0 never set when ZERO_REG=1.
- rdPending[i] = pend[rdAddr_i], masked to 0 when BYPASS=1 and a same-cycle write hits rdAddr_i.
- Multiple read ports to the same address return identical data.

Decomposition:
- Shared package reg_file_pkg: FSM state enum (CLEAR/READY), default width constants, pack/unpack index helpers for read ports.
- One sub-module, reg_file_bypass: per-read-port mux (stored value / A / B, zero suppression). Instantiated NUM_RD times in a generate loop.

Test Plan:
1. Reset (ADDR_W=5) -> ready=0 for 32 edges, 1 after the 32nd. All 32 reads return 0x0; rdPending all 0.
2. Write A addr 3 = 0xDEADBEEF, read port 0 addr 3 the same cycle. BYPASS=1 -> 0xDEADBEEF that cycle. BYPASS=0 -> old 0, then 0xDEADBEEF next cycle.
3. wrEnA addr 7 = 0x11 with wrEnB addr 7 = 0x22 -> wrCollide=1; addr 7 reads 0x22 afterwards. Write 0x55 to addr 0 -> addr 0 still reads 0.
4. issueEn addr 9 -> rdPending=1 for addr 9 next cycle. Write addr 9 -> pending clears after that edge (masked same cycle with BYPASS=1). Same-edge issue and write to addr 9 -> remains pending.
5. Fill regs with nonzero values, pulse clrReq -> ready=0 for 32 cycles; writes during clear are dropped; all regs read 0 afterwards.
6. Assert rst_n low at clrIdx=10 -> ready stays 0 and pending stays 0; ready rises 32 edges after release.
